cpu4_mc_controller: RTL and testbench
=====================================

// Module: cpu4_mc_controller
// PURPOSE
//  Multicycle sequencer for the cpu4 datapath: a Moore FSM that takes the IR opcode/funct and ALU zero
//  and drives the datapath enables/muxes one step per cycle (fetch, decode, execute, mem, writeback).
//  Adds a mem_req/mem_ready handshake to a shared instr/data memory, a memory-timeout watchdog and a
//  sticky halt on illegal instructions. Replaces the combinational controller when the core runs multicycle.
// PARAMETERS
//  MEM_TIMEOUT  255  consecutive not-ready cycles in a memory state before halt; 0 disables watchdog
//  TO_W         8    width of wait counter; MEM_TIMEOUT must be < 2**TO_W
// PORTS
//  clk         in   1  core clock
//  reset       in   1  synchronous, active-high reset
//  opcode      in   6  IR[31:26], valid from DECODE onward
//  funct       in   6  IR[5:0]
//  zero        in   1  ALU zero flag
//  mem_ready   in   1  memory completes the current access this cycle
//  mem_req     out  1  memory access request (FETCH, MEMRD, MEMWR)
//  memwrite    out  1  write qualifier for mem_req (MEMWR only)
//  iord        out  1  0=PC address, 1=ALUOut address
//  irwrite     out  1  load IR (FETCH & mem_ready)
//  pcen        out  1  PC load = pcwrite | (branch & zero)
//  regwrite    out  1  register file write
//  regdst      out  1  1=rd, 0=rt
//  memtoreg    out  1  1=data reg, 0=ALUOut
//  alusrca     out  1  0=PC, 1=rs
//  alusrcb     out  2  00=rt, 01=const 4, 10=signimm, 11=signimm<<2
//  pcsrc       out  2  00=ALU result, 01=ALUOut, 10=jump target
//  alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//  halted      out  1  sticky, high in HALT
//  halt_cause  out  2  00 none, 01 illegal instr, 10 mem timeout; held until reset
//  state_o     out  4  current state (debug)
// BEHAVIOUR
//  - State register updates on posedge clk. Outputs are combinational from state; only irwrite/pcen
//    (gated by mem_ready/zero) and alucontrol in RTYPE_EX (from funct) depend on inputs.
//  - While reset=1: next state FETCH, wait counter 0, halt_cause 00. Every enable output
//    (mem_req, memwrite, irwrite, pcen, regwrite) is forced 0. Every other output is 0, except
//    alusrcb=01 and alucontrol=010. Reset mid-access abandons it.
//  - Opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
//  - Legal funct (R only): 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
//  - Defaults in every state: all enables 0, alucontrol=010.
//  - FETCH: mem_req, iord=0, alusrca=0, alusrcb=01, pcsrc=00. mem_ready -> irwrite=1, pcen=1, go DECODE;
//    else stay.
//  - DECODE: alusrca=0, alusrcb=11 (branch target into ALUOut).
//    Next: lw/sw->MEMADR, R->RTYPE_EX, beq->BEQ_EX, addi->ADDI_EX, j->J_EX.
//    Unknown opcode, or R with illegal funct -> HALT, cause 01.
//  - MEMADR: alusrca=1, alusrcb=10 -> MEMRD if lw, MEMWR if sw.
//  - MEMRD: mem_req, iord=1; mem_ready -> MEMWB. MEMWB: regwrite, regdst=0, memtoreg=1 -> FETCH.
//  - MEMWR: mem_req, memwrite, iord=1; mem_ready -> FETCH (write commits on ready cycle).
//  - RTYPE_EX: alusrca=1, alusrcb=00, alucontrol from funct -> ALUWB.
//    ALUWB: regwrite, regdst=1, memtoreg=0 -> FETCH.
//  - BEQ_EX: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, pcen=zero -> FETCH.
//  - ADDI_EX: alusrca=1, alusrcb=10 -> ADDI_WB. ADDI_WB: regwrite, regdst=0, memtoreg=0 -> FETCH.
//  - J_EX: pcsrc=10, pcen=1 -> FETCH.
//  - HALT: all enables 0, halted=1; exits only via reset.
//  - Watchdog: counter clears on entry to FETCH/MEMRD/MEMWR and increments each not-ready cycle there.
//    When MEM_TIMEOUT!=0 and the counter would reach MEM_TIMEOUT -> HALT, cause 10.
//    mem_ready in the same cycle wins over timeout. Counter saturates; it never wraps.
//  - Instruction latency: lw 5, sw 4, R/addi 4, beq/j 3 cycles, plus memory wait cycles.
// STRUCTURE
//  - defines.v: state encodings (4-bit), opcode/funct constants, ALUCTL_* and halt-cause codes.
//  - Sub-module cpu4_aludec (combinational funct->alucontrol, plus funct_legal flag), used in DECODE/RTYPE_EX.
//  - Rest in one file: state register, next-state logic, output decode, wait counter.
// TESTING
//  - reset high 2 cycles, mem_ready=1 -> state_o=FETCH; mem_req/pcen/irwrite/regwrite/memwrite=0
//    during reset; halted=0, halt_cause=00.
//  - add (000000/100000), mem_ready=1 -> FETCH,DECODE,RTYPE_EX,ALUWB.
//    alucontrol=010 in EX; regwrite=1, regdst=1 only in ALUWB; irwrite exactly once.
//  - lw, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles; regwrite with memtoreg=1 once;
//    8 cycles total.
//  - beq with zero=1 -> pcen=1, pcsrc=01, alucontrol=110 in BEQ_EX; repeat with zero=0 -> pcen=0.
//  - opcode 111111 -> HALT after DECODE; halted=1, cause 01 held 10 cycles, no enables.
//    reset -> FETCH, cause 00.
//  - MEM_TIMEOUT=4, mem_ready=0 in FETCH -> HALT cause 10 after 4 cycles.
//    Ready on 4th cycle -> DECODE, no halt.

Source files
------------

// File: rtl/cpu4_mc_pkg.sv
// Shared encodings for the cpu4 multicycle controller: FSM states, opcodes,
// R-type function codes, ALU control codes and halt causes.
package cpu4_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_ALUWB    = 4'd7,
        S_BEQ_EX   = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_J_EX     = 4'd11,
        S_HALT     = 4'd12
    } state_e;

    typedef enum logic [1:0] {
        HC_NONE    = 2'b00,
        HC_ILLEGAL = 2'b01,
        HC_TIMEOUT = 2'b10
    } halt_cause_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALUCTL_ADD = 3'b010;
    localparam logic [2:0] ALUCTL_SUB = 3'b110;
    localparam logic [2:0] ALUCTL_AND = 3'b000;
    localparam logic [2:0] ALUCTL_OR  = 3'b001;
    localparam logic [2:0] ALUCTL_SLT = 3'b111;

    // Memory-facing states share the handshake and the watchdog.
    function automatic logic is_mem_state(state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/cpu4_mc_controller_aludec.sv
// R-type ALU decoder: maps funct to alucontrol and flags whether funct is
// one of the supported operations.
module cpu4_aludec
    import cpu4_mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       legal
);

    always_comb begin
        alucontrol = ALUCTL_ADD;
        legal      = 1'b1;
        case (funct)
            FN_ADD:  alucontrol = ALUCTL_ADD;
            FN_SUB:  alucontrol = ALUCTL_SUB;
            FN_AND:  alucontrol = ALUCTL_AND;
            FN_OR:   alucontrol = ALUCTL_OR;
            FN_SLT:  alucontrol = ALUCTL_SLT;
            default: legal      = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu4_mc_controller.sv
// Multicycle Moore sequencer for the cpu4 datapath with a memory handshake,
// a not-ready watchdog and a sticky halt on illegal instructions.
module cpu4_mc_controller
    import cpu4_mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcen,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       halted,
    output logic [1:0] halt_cause,
    output logic [3:0] state_o
);

    state_e          state, state_nx;
    halt_cause_e     cause, cause_nx;
    logic [TO_W-1:0] wcnt, wcnt_nx, wcnt_inc;
    logic            to_hit;
    logic [2:0]      rt_alu;
    logic            funct_ok;

    cpu4_aludec u_aludec (
        .funct      (funct),
        .alucontrol (rt_alu),
        .legal      (funct_ok)
    );

    // Saturating increment; the watchdog fires on the cycle the count would reach the limit.
    assign wcnt_inc = (&wcnt) ? wcnt : wcnt + 1'b1;
    assign to_hit   = (MEM_TIMEOUT != 0) && (wcnt_inc == TO_W'(MEM_TIMEOUT));

    always_comb begin
        state_nx = state;
        cause_nx = cause;
        wcnt_nx  = '0;
        if (is_mem_state(state)) begin
            if (mem_ready) begin
                case (state)
                    S_FETCH: state_nx = S_DECODE;
                    S_MEMRD: state_nx = S_MEMWB;
                    default: state_nx = S_FETCH;
                endcase
            end else if (to_hit) begin
                state_nx = S_HALT;
                cause_nx = HC_TIMEOUT;
            end else begin
                wcnt_nx = wcnt_inc;
            end
        end else begin
            case (state)
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: state_nx = S_MEMADR;
                        OP_R:         state_nx = funct_ok ? S_RTYPE_EX : S_HALT;
                        OP_BEQ:       state_nx = S_BEQ_EX;
                        OP_ADDI:      state_nx = S_ADDI_EX;
                        OP_J:         state_nx = S_J_EX;
                        default:      state_nx = S_HALT;
                    endcase
                    if (state_nx == S_HALT) cause_nx = HC_ILLEGAL;
                end
                S_MEMADR:   state_nx = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                S_RTYPE_EX: state_nx = S_ALUWB;
                S_ADDI_EX:  state_nx = S_ADDI_WB;
                S_HALT:     state_nx = S_HALT;
                default:    state_nx = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            cause <= HC_NONE;
            wcnt  <= '0;
        end else begin
            state <= state_nx;
            cause <= cause_nx;
            wcnt  <= wcnt_nx;
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcen       = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = ALUCTL_ADD;
        halted     = 1'b0;
        halt_cause = 2'b00;
        state_o    = 4'd0;
        if (reset) begin
            alusrcb = 2'b01;
        end else begin
            state_o    = state;
            halt_cause = cause;
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    alusrcb = 2'b01;
                    irwrite = mem_ready;
                    pcen    = mem_ready;
                end
                S_DECODE: alusrcb = 2'b11;
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                S_MEMWR: begin
                    mem_req  = 1'b1;
                    memwrite = 1'b1;
                    iord     = 1'b1;
                end
                S_RTYPE_EX: begin
                    alusrca    = 1'b1;
                    alucontrol = rt_alu;
                end
                S_ALUWB: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                end
                S_BEQ_EX: begin
                    alusrca    = 1'b1;
                    alucontrol = ALUCTL_SUB;
                    pcsrc      = 2'b01;
                    pcen       = zero;
                end
                S_ADDI_EX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_ADDI_WB: regwrite = 1'b1;
                S_J_EX: begin
                    pcsrc = 2'b10;
                    pcen  = 1'b1;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu4_mc_controller.sv
// Directed plus randomized instruction stream for the multicycle controller,
// checked cycle by cycle against an instruction-level path model.
module tb_cpu4_mc_controller;
    import cpu4_mc_pkg::state_e;
    import cpu4_mc_pkg::S_FETCH;
    import cpu4_mc_pkg::S_DECODE;
    import cpu4_mc_pkg::S_MEMADR;
    import cpu4_mc_pkg::S_MEMRD;
    import cpu4_mc_pkg::S_MEMWB;
    import cpu4_mc_pkg::S_MEMWR;
    import cpu4_mc_pkg::S_RTYPE_EX;
    import cpu4_mc_pkg::S_ALUWB;
    import cpu4_mc_pkg::S_BEQ_EX;
    import cpu4_mc_pkg::S_ADDI_EX;
    import cpu4_mc_pkg::S_ADDI_WB;
    import cpu4_mc_pkg::S_J_EX;
    import cpu4_mc_pkg::S_HALT;

    localparam int TO = 4;

    localparam logic [5:0] R_OP = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
    localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010;

    logic       clk = 1'b0;
    logic       reset, zero, mem_ready;
    logic [5:0] opcode, funct;
    logic       mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg, alusrca, halted;
    logic [1:0] alusrcb, pcsrc, halt_cause;
    logic [2:0] alucontrol;
    logic [3:0] state_o;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        state_e st;
        logic   mr;
    } step_t;

    step_t      path[$];
    logic [1:0] m_cause;

    always #5 clk = ~clk;

    cpu4_mc_controller #(.MEM_TIMEOUT(TO), .TO_W(8)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .memwrite(memwrite), .iord(iord),
        .irwrite(irwrite), .pcen(pcen), .regwrite(regwrite), .regdst(regdst),
        .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .alucontrol(alucontrol), .halted(halted), .halt_cause(halt_cause), .state_o(state_o)
    );

    wire [22:0] obs = {state_o, mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst,
                       memtoreg, alusrca, alusrcb, pcsrc, alucontrol, halted, halt_cause};

    function automatic logic [2:0] funct_alu(logic [5:0] fn);
        case (fn)
            F_SUB:   return 3'b110;
            F_AND:   return 3'b000;
            F_OR:    return 3'b001;
            F_SLT:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic bit instr_legal(logic [5:0] op, logic [5:0] fn);
        if (op == R_OP) return fn inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
        return op inside {LW, SW, BEQ, ADDI, JMP};
    endfunction

    // Control word required in each step, straight from the control table.
    function automatic logic [22:0] exp_out(state_e st, logic mr, logic z, logic [5:0] fn,
                                            logic [1:0] hc);
        logic rq, mw, io, irw, pce, rw, rd, m2r, sa, hl;
        logic [1:0] sb, ps;
        logic [2:0] ac;
        {rq, mw, io, irw, pce, rw, rd, m2r, sa, hl} = '0;
        sb = 2'b00; ps = 2'b00; ac = 3'b010;
        case (st)
            S_FETCH:    begin rq = 1; sb = 2'b01; irw = mr; pce = mr; end
            S_DECODE:   sb = 2'b11;
            S_MEMADR:   begin sa = 1; sb = 2'b10; end
            S_MEMRD:    begin rq = 1; io = 1; end
            S_MEMWB:    begin rw = 1; m2r = 1; end
            S_MEMWR:    begin rq = 1; mw = 1; io = 1; end
            S_RTYPE_EX: begin sa = 1; ac = funct_alu(fn); end
            S_ALUWB:    begin rw = 1; rd = 1; end
            S_BEQ_EX:   begin sa = 1; ac = 3'b110; ps = 2'b01; pce = z; end
            S_ADDI_EX:  begin sa = 1; sb = 2'b10; end
            S_ADDI_WB:  rw = 1;
            S_J_EX:     begin ps = 2'b10; pce = 1; end
            S_HALT:     hl = 1;
            default:    ;
        endcase
        return {4'(st), rq, mw, io, irw, pce, rw, rd, m2r, sa, sb, ps, ac, hl,
                (st == S_HALT) ? hc : 2'b00};
    endfunction

    task automatic chk(input string tag, input logic [22:0] got, input logic [22:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        logic [22:0] rv;
        rv = {4'd0, 9'b0, 2'b01, 2'b00, 3'b010, 1'b0, 2'b00};
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mem_ready = (i == 0) ? 1'b1 : 1'(($urandom));
            @(negedge clk);
            chk($sformatf("reset_c%0d", i), obs, rv);
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    // Appends a memory phase of w not-ready cycles; returns 1 if the watchdog ends it.
    task automatic push_mem(input state_e st, input int w, output bit timed_out);
        timed_out = (w >= TO);
        for (int i = 0; i < ((w >= TO) ? TO : w); i++) path.push_back('{st, 1'b0});
        if (!timed_out) path.push_back('{st, 1'b1});
        else m_cause = 2'b10;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fw, input int mw, input int hold);
        bit fto, mto, halt;
        int irw_seen;
        path.delete();
        m_cause = 2'b00;
        mto = 0;
        opcode = op; funct = fn; zero = z;
        push_mem(S_FETCH, fw, fto);
        halt = fto;
        if (!fto) begin
            path.push_back('{S_DECODE, 1'($urandom)});
            if (!instr_legal(op, fn)) begin
                halt = 1; m_cause = 2'b01;
            end else if (op == LW || op == SW) begin
                path.push_back('{S_MEMADR, 1'($urandom)});
                push_mem((op == LW) ? S_MEMRD : S_MEMWR, mw, mto);
                halt = mto;
                if (!mto && op == LW) path.push_back('{S_MEMWB, 1'($urandom)});
            end else if (op == R_OP) begin
                path.push_back('{S_RTYPE_EX, 1'($urandom)});
                path.push_back('{S_ALUWB, 1'($urandom)});
            end else if (op == BEQ) begin
                path.push_back('{S_BEQ_EX, 1'($urandom)});
            end else if (op == ADDI) begin
                path.push_back('{S_ADDI_EX, 1'($urandom)});
                path.push_back('{S_ADDI_WB, 1'($urandom)});
            end else begin
                path.push_back('{S_J_EX, 1'($urandom)});
            end
        end
        if (halt) for (int i = 0; i < hold; i++) path.push_back('{S_HALT, 1'($urandom)});
        irw_seen = 0;
        foreach (path[i]) begin
            mem_ready = path[i].mr;
            @(negedge clk);
            chk($sformatf("op%b_%s_c%0d", op, path[i].st.name(), i), obs,
                exp_out(path[i].st, path[i].mr, z, fn, m_cause));
            if (irwrite === 1'b1) irw_seen++;
            @(posedge clk); #1;
        end
        chk($sformatf("op%b_irwrite_count", op), 23'(irw_seen), fto ? 23'd0 : 23'd1);
        if (halt) do_reset();
    endtask

    initial begin
        logic [5:0] ops[8];
        logic [5:0] fns[5];
        logic [5:0] op, fn;
        int fw, mw;
        ops = '{R_OP, LW, SW, BEQ, ADDI, JMP, 6'b111111, R_OP};
        fns = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT};
        reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = '0; funct = '0;
        do_reset();

        run_instr(R_OP, F_ADD, 1'b0, 0, 0, 0);
        run_instr(LW, 6'h00, 1'b0, 0, 3, 0);
        run_instr(SW, 6'h00, 1'b0, 1, 2, 0);
        run_instr(BEQ, 6'h00, 1'b1, 0, 0, 0);
        run_instr(BEQ, 6'h00, 1'b0, 0, 0, 0);
        run_instr(ADDI, 6'h00, 1'b0, 0, 0, 0);
        run_instr(JMP, 6'h00, 1'b0, 0, 0, 0);
        run_instr(R_OP, F_SLT, 1'b0, 0, 0, 0);
        run_instr(6'b111111, 6'h00, 1'b0, 0, 0, 10);
        run_instr(R_OP, 6'b111111, 1'b0, 0, 0, 3);
        run_instr(R_OP, F_SUB, 1'b0, TO, 0, 3);
        run_instr(R_OP, F_OR, 1'b0, TO - 1, 0, 0);
        run_instr(LW, 6'h00, 1'b0, 0, TO, 2);

        for (int n = 0; n < 200; n++) begin
            op = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            fw = ($urandom_range(0, 11) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, TO - 1);
            mw = ($urandom_range(0, 11) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, TO - 1);
            run_instr(op, fn, 1'($urandom), fw, mw, $urandom_range(1, 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
